bit_serial_adder: RTL and testbench

//   Multi-bit adder that feeds one 1-bit full-adder cell, LSB first, one bit per clock.
//   A registered carry loops back into the cell each cycle.

---
 rtl/bit_serial_adder_if.sv | 21 ++
 rtl/bit_serial_adder.sv | 68 ++++++
 tb/tb_bit_serial_adder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_if.sv
// bit_serial_adder_if: operand/result valid-ready bundle for bit_serial_adder
interface bit_serial_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    modport master (
        output in_valid, a_in, b_in, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a_in, b_in, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit add done LSB first through one full-adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    bit_serial_adder_if.slave bus
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0]    cnt;
    logic             c, s, c_next, accept, last;
    full_adder u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(c), .s(s), .co(c_next));
    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = cnt == CW'(WIDTH - 1);
    // State register; reset always lands in IDLE, abandoning any operation
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    // Next state: accept in IDLE, WIDTH shift cycles in RUN, hold DONE until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.in_valid ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = bus.out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    // Operand/sum shifters, loop-back carry and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c      <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh <= bus.a_in;
            b_sh <= bus.b_in;
            c    <= bus.cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            sum_sh <= WIDTH'({s, sum_sh} >> 1);
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            c      <= c_next;
            cnt    <= cnt + 1'b1;
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.sum       = bus.out_valid ? sum_sh : '0;
    assign bus.cout      = bus.out_valid & c;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: vector table, random and corner sequences for WIDTH=8 and WIDTH=1
module tb_bit_serial_adder;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    bit_serial_adder_if #(.WIDTH(8)) b8 ();
    bit_serial_adder_if #(.WIDTH(1)) b1 ();
    bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    bit_serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_q[$];
    logic [8:0] res_q[$];
    vec_t vt[8];
    logic [7:0] sa[3];
    logic [7:0] sb[3];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b8.in_valid && b8.in_ready) acc_q.push_back(cyc);
        if (b8.out_valid && b8.out_ready) res_q.push_back({b8.cout, b8.sum});
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output logic [8:0] r, output int lat);
        int n = 0;
        while (!b8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        b8.a_in = a;
        b8.b_in = b;
        b8.cin = ci;
        b8.in_valid = 1;
        @(negedge clk);
        b8.in_valid = 0;
        lat = 0;
        while (!b8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = {b8.cout, b8.sum};
    endtask
    initial begin
        logic [8:0] r;
        logic [8:0] exp9;
        int lat, seen;
        vt[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vt[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vt[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        sa = '{8'h10, 8'h7F, 8'h80};
        sb = '{8'h20, 8'h01, 8'h80};
        b8.in_valid = 0; b8.a_in = 0; b8.b_in = 0; b8.cin = 0; b8.out_ready = 1;
        b1.in_valid = 0; b1.a_in = 0; b1.b_in = 0; b1.cin = 0; b1.out_ready = 1;
        repeat (2) @(negedge clk);
        b8.in_valid = 1;
        b8.a_in = 8'h11;
        @(negedge clk);
        chk("reset busy", b8.busy, 0);
        chk("reset out_valid", b8.out_valid, 0);
        chk("reset sum", b8.sum, 0);
        chk("reset cout", b8.cout, 0);
        b8.in_valid = 0;
        rst = 0;
        @(negedge clk);
        chk("in_ready after reset", b8.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            op8(vt[i].a, vt[i].b, vt[i].ci, r, lat);
            chk($sformatf("vec%0d sum", i), r[7:0], vt[i].s);
            chk($sformatf("vec%0d cout", i), r[8], vt[i].co);
            chk($sformatf("vec%0d latency", i), lat, 8);
            chk($sformatf("vec%0d in_ready in DONE", i), b8.in_ready, 0);
            @(negedge clk);
            chk($sformatf("vec%0d in_ready after take", i), b8.in_ready, 1);
            chk($sformatf("vec%0d out_valid after take", i), b8.out_valid, 0);
        end
        for (int i = 0; i < 30; i++) begin
            logic [7:0] a, b;
            logic ci;
            a = 8'($urandom);
            b = 8'($urandom);
            ci = 1'($urandom);
            op8(a, b, ci, r, lat);
            exp9 = 9'(a) + 9'(b) + 9'(ci);
            chk($sformatf("rand %0h+%0h+%0h", a, b, ci), r, exp9);
            @(negedge clk);
        end
        b8.out_ready = 0;
        op8(8'h5A, 8'h33, 1'b0, r, lat);
        chk("bp result", r, 9'h08D);
        b8.a_in = 8'h01;
        b8.b_in = 8'h02;
        b8.cin = 0;
        b8.in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid", b8.out_valid, 1);
            chk("bp sum", b8.sum, 8'h8D);
            chk("bp cout", b8.cout, 0);
            chk("bp in_ready", b8.in_ready, 0);
        end
        b8.out_ready = 1;
        @(negedge clk);
        chk("bp release out_valid", b8.out_valid, 0);
        chk("bp release in_ready", b8.in_ready, 1);
        chk("bp release busy", b8.busy, 0);
        @(negedge clk);
        chk("bp accept busy", b8.busy, 1);
        b8.in_valid = 0;
        lat = 0;
        while (!b8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("bp next result", {b8.cout, b8.sum}, 9'h003);
        @(negedge clk);
        b8.a_in = 8'h0F;
        b8.b_in = 8'h01;
        b8.cin = 0;
        b8.in_valid = 1;
        @(negedge clk);
        b8.in_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort out_valid", b8.out_valid, 0);
        chk("abort sum", b8.sum, 0);
        chk("abort busy", b8.busy, 0);
        chk("abort in_ready", b8.in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (b8.out_valid) seen++;
        end
        chk("abort no out_valid", seen, 0);
        op8(8'h01, 8'h02, 1'b0, r, lat);
        chk("post abort result", r, 9'h003);
        chk("post abort latency", lat, 8);
        @(negedge clk);
        acc_q.delete();
        res_q.delete();
        b8.out_ready = 1;
        b8.a_in = sa[0];
        b8.b_in = sb[0];
        b8.cin = 0;
        b8.in_valid = 1;
        for (int t = 0; t < 60 && res_q.size() < 3; t++) begin
            @(negedge clk);
            if (acc_q.size() >= 3) b8.in_valid = 0;
            else begin
                b8.a_in = sa[acc_q.size()];
                b8.b_in = sb[acc_q.size()];
            end
        end
        b8.in_valid = 0;
        chk("stream results", res_q.size(), 3);
        chk("stream accepts", acc_q.size(), 3);
        for (int i = 0; i < 3 && i < res_q.size(); i++)
            chk($sformatf("stream res%0d", i), res_q[i], 9'(sa[i]) + 9'(sb[i]));
        for (int i = 1; i < 3 && i < acc_q.size(); i++)
            chk($sformatf("stream spacing%0d", i), acc_q[i] - acc_q[i-1], 10);
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (!b1.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            b1.a_in = i[2];
            b1.b_in = i[1];
            b1.cin = i[0];
            b1.in_valid = 1;
            @(negedge clk);
            b1.in_valid = 0;
            lat = 0;
            while (!b1.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("w1 latency %0d", i), lat, 1);
            chk($sformatf("w1 result %0d", i), {b1.cout, b1.sum}, ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
